// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: EX-stage issue and hazard controller.
// Decides whether the instruction in OF advances into the ALU. A 16-entry
// countdown scoreboard covers read-after-write hazards; there is no forwarding.
// A taken branch from the ALU redirects the PC and squashes IF/ID/OF for
// FLUSH_CYC cycles.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module ex_issue_ctrl #(
  parameter int WB_LAT     = 3,
  parameter int LOAD_EXTRA = 1,
  parameter int FLUSH_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        of_valid,
  input  logic [3:0]  of_src1,
  input  logic [3:0]  of_src2,
  input  logic        of_src1_used,
  input  logic        of_src2_used,
  input  logic [3:0]  of_dst,
  input  logic        of_is_write,
  input  logic        of_is_load,
  input  logic [8:0]  ex_branch,
  output logic        issue,
  output logic        stall,
  output logic        flush,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic [15:0] busy_mask
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cyc,
  output logic [15:0] perf_flush_evt
`endif
);

  localparam logic [2:0] ALU_BUSY   = 3'(WB_LAT);
  localparam logic [2:0] LOAD_BUSY  = 3'(WB_LAT + LOAD_EXTRA);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

  logic [2:0]  cnt [16];
  logic [2:0]  flush_cnt;
  logic [15:0] busy_vec;
  logic        haz;
  logic        br;
  logic        flush_int;
  logic        issue_int;
  logic        stall_int;

  // Busy view of the scoreboard: a register is unreadable while its counter runs
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      busy_vec[r] = (cnt[r] != 3'd0);
    end
  end

  // Hazard check, redirect detection and the issue/stall decision
  always_comb begin
    haz       = (of_src1_used & busy_vec[of_src1]) | (of_src2_used & busy_vec[of_src2]);
    // A branch arriving while a squash is already running belongs to the
    // wrong path and is dropped.
    br        = ex_branch[8] & (flush_cnt == 3'd0);
    flush_int = br | (flush_cnt != 3'd0);
    // Squash wins over a pending hazard: the OF instruction is discarded,
    // so it neither issues nor stalls.
    issue_int = of_valid & ~haz & ~flush_int;
    stall_int = of_valid & ~issue_int & ~flush_int;
  end

  // Drive the outputs; control outputs are held low for the whole reset
  always_comb begin
    issue     = issue_int & ~rst;
    stall     = stall_int & ~rst;
    flush     = flush_int & ~rst;
    pc_load   = br & ~rst;
    pc_target = ex_branch[7:0];
    busy_mask = rst ? 16'h0000 : busy_vec;
  end

  // Scoreboard: count down every busy entry, reload the destination of an issued writer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        cnt[r] <= 3'd0;
      end
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (issue_int && of_is_write && (of_dst == 4'(r))) begin
          cnt[r] <= of_is_load ? LOAD_BUSY : ALU_BUSY;
        end else if (cnt[r] != 3'd0) begin
          cnt[r] <= cnt[r] - 3'd1;
        end
      end
    end
  end

  // Squash counter: covers the FLUSH_CYC-1 cycles after the redirect cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 3'd0;
    end else if (br) begin
      flush_cnt <= FLUSH_INIT;
    end else if (flush_cnt != 3'd0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end
    return v;
  endfunction

  // Saturating counters of stall cycles and redirect events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= 16'h0000;
      perf_flush_evt <= 16'h0000;
    end else begin
      perf_stall_cyc <= sat_inc(perf_stall_cyc, stall_int);
      perf_flush_evt <= sat_inc(perf_flush_evt, br);
    end
  end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb_ex_issue_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a cycle-stamp model (each register carries the first
// cycle at which it is readable again, the flush carries its end cycle).
module tb_ex_issue_ctrl;

  localparam int WB_LAT     = 3;
  localparam int LOAD_EXTRA = 1;
  localparam int FLUSH_CYC  = 2;

  logic        clk;
  logic        rst;
  logic        of_valid;
  logic [3:0]  of_src1;
  logic [3:0]  of_src2;
  logic        of_src1_used;
  logic        of_src2_used;
  logic [3:0]  of_dst;
  logic        of_is_write;
  logic        of_is_load;
  logic [8:0]  ex_branch;
  logic        issue;
  logic        stall;
  logic        flush;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic [15:0] busy_mask;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] perf_stall_cyc;
  logic [15:0] perf_flush_evt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  int ready_at [16];
  int flush_until = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  ex_issue_ctrl #(
    .WB_LAT(WB_LAT),
    .LOAD_EXTRA(LOAD_EXTRA),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .of_valid(of_valid),
    .of_src1(of_src1),
    .of_src2(of_src2),
    .of_src1_used(of_src1_used),
    .of_src2_used(of_src2_used),
    .of_dst(of_dst),
    .of_is_write(of_is_write),
    .of_is_load(of_is_load),
    .ex_branch(ex_branch),
    .issue(issue),
    .stall(stall),
    .flush(flush),
    .pc_load(pc_load),
    .pc_target(pc_target),
    .busy_mask(busy_mask)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_evt(perf_flush_evt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model compare: runs mid-cycle, after inputs have settled
  always @(negedge clk) begin
    logic        e_issue, e_stall, e_flush, e_br, haz;
    logic [15:0] e_mask;
    e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_br = 1'b0; e_mask = 16'h0;
    if (rst) begin
      for (int r = 0; r < 16; r++) ready_at[r] = 0;
      flush_until = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      for (int r = 0; r < 16; r++) e_mask[r] = (cyc < ready_at[r]);
      haz     = (of_src1_used && e_mask[of_src1]) || (of_src2_used && e_mask[of_src2]);
      e_br    = ex_branch[8] && (cyc >= flush_until);
      e_flush = e_br || (cyc < flush_until);
      e_issue = of_valid && !haz && !e_flush;
      e_stall = of_valid && !e_issue && !e_flush;
    end
    chk("m_issue", issue, e_issue);
    chk("m_stall", stall, e_stall);
    chk("m_flush", flush, e_flush);
    chk("m_pc_load", pc_load, e_br);
    chk("m_pc_target", pc_target, ex_branch[7:0]);
    chk("m_busy_mask", busy_mask, e_mask);
`ifdef HAZ_PERF_CNT_EN
    chk("m_perf_stall", perf_stall_cyc, m_stall_cnt);
    chk("m_perf_flush", perf_flush_evt, m_flush_cnt);
`endif
    if (!rst) begin
      if (e_br) flush_until = cyc + FLUSH_CYC;
      if (e_issue && of_is_write)
        ready_at[of_dst] = cyc + 1 + WB_LAT + (of_is_load ? LOAD_EXTRA : 0);
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_br && m_flush_cnt < 65535) m_flush_cnt++;
    end
    cyc++;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_op();
    of_valid = 1'b0; of_src1 = 4'd0; of_src2 = 4'd0;
    of_src1_used = 1'b0; of_src2_used = 1'b0;
    of_dst = 4'd0; of_is_write = 1'b0; of_is_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_op();
    ex_branch = 9'h0AB;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_issue", issue, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_pc_load", pc_load, 1'b0);
    chk("rst_busy", busy_mask, 16'h0000);
    chk("rst_pc_target", pc_target, 8'hAB);

    // Release with an instruction reading nothing; it writes R5
    next_cyc();
    rst = 1'b0; ex_branch = 9'h000;
    of_valid = 1'b1; of_is_write = 1'b1; of_dst = 4'd5;
    #1;
    chk("first_issue", issue, 1'b1);
    chk("first_busy", busy_mask, 16'h0000);

    // Consumer of R5 stalls three cycles then issues
    for (int k = 1; k <= 3; k++) begin
      next_cyc();
      of_is_write = 1'b0; of_src1 = 4'd5; of_src1_used = 1'b1;
      #1;
      chk("raw_stall", stall, 1'b1);
      chk("raw_busy5", busy_mask[5], 1'b1);
    end
    next_cyc();
    #1;
    chk("raw_issue", issue, 1'b1);
    chk("raw_busy5_clr", busy_mask[5], 1'b0);

    // Load to R2 then a consumer on src2: four stall cycles
    next_cyc();
    clr_op();
    of_valid = 1'b1; of_is_write = 1'b1; of_is_load = 1'b1; of_dst = 4'd2;
    #1;
    chk("ld_issue", issue, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      clr_op();
      of_valid = 1'b1; of_src2 = 4'd2; of_src2_used = 1'b1;
      #1;
      chk("ld_stall", stall, 1'b1);
    end
    next_cyc();
    #1;
    chk("ld_issue_after", issue, 1'b1);

    // Taken branch, second branch right behind it is ignored
    next_cyc();
    clr_op();
    of_valid = 1'b1; ex_branch = 9'h13C;
    #1;
    chk("br_pc_load", pc_load, 1'b1);
    chk("br_target", pc_target, 8'h3C);
    chk("br_flush", flush, 1'b1);
    chk("br_issue", issue, 1'b0);
    next_cyc();
    ex_branch = 9'h110;
    #1;
    chk("br2_pc_load", pc_load, 1'b0);
    chk("br2_flush", flush, 1'b1);
    chk("br2_issue", issue, 1'b0);
    next_cyc();
    ex_branch = 9'h000;
    #1;
    chk("br_end_flush", flush, 1'b0);
    chk("br_end_issue", issue, 1'b1);

    // Branch while OF is stalled on R7; the squashed writer of R9 leaves no trace
    next_cyc();
    clr_op();
    of_valid = 1'b1; of_is_write = 1'b1; of_dst = 4'd7;
    #1;
    chk("bs_prod_issue", issue, 1'b1);
    next_cyc();
    of_src1 = 4'd7; of_src1_used = 1'b1; of_dst = 4'd9;
    #1;
    chk("bs_stall", stall, 1'b1);
    next_cyc();
    ex_branch = 9'h155;
    #1;
    chk("bs_br_stall", stall, 1'b0);
    chk("bs_br_flush", flush, 1'b1);
    chk("bs_br_busy", busy_mask, 16'h0080);
    next_cyc();
    ex_branch = 9'h000;
    #1;
    chk("bs_flush2", flush, 1'b1);
    chk("bs_busy_after", busy_mask, 16'h0080);
    next_cyc();
    #1;
    chk("bs_reissue", issue, 1'b1);
    next_cyc();
    clr_op();
    repeat (4) next_cyc();

    // Asynchronous reset mid-stall with R2 and R5 busy
    of_valid = 1'b1; of_is_write = 1'b1; of_dst = 4'd2;
    next_cyc();
    of_dst = 4'd5;
    #1;
    chk("ar_busy_r2", busy_mask, 16'h0004);
    next_cyc();
    of_is_write = 1'b0; of_src1 = 4'd2; of_src1_used = 1'b1;
    #1;
    chk("ar_busy", busy_mask, 16'h0024);
    chk("ar_stall", stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_issue", issue, 1'b0);
    chk("ar_stall0", stall, 1'b0);
    chk("ar_flush", flush, 1'b0);
    chk("ar_pc_load", pc_load, 1'b0);
    chk("ar_busy0", busy_mask, 16'h0000);
`ifdef HAZ_PERF_CNT_EN
    chk("ar_perf_stall", perf_stall_cyc, 16'h0000);
    chk("ar_perf_flush", perf_flush_evt, 16'h0000);
`endif
    next_cyc();
    rst = 1'b0;
    #1;
    chk("ar_release_issue", issue, 1'b1);
    chk("ar_release_busy", busy_mask, 16'h0000);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      next_cyc();
      rst          = ($urandom_range(0, 249) == 0);
      of_valid     = ($urandom_range(0, 3) != 0);
      of_src1      = 4'($urandom_range(0, 5));
      of_src2      = 4'($urandom_range(0, 5));
      of_src1_used = $urandom_range(0, 1) != 0;
      of_src2_used = $urandom_range(0, 1) != 0;
      of_dst       = 4'($urandom_range(0, 5));
      of_is_write  = $urandom_range(0, 2) != 0;
      of_is_load   = ($urandom_range(0, 3) == 0);
      ex_branch    = {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255))};
    end

    next_cyc();
    rst = 1'b0;
    clr_op();
    ex_branch = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
# ex_issue_ctrl

Issue and hazard controller for the EX stage. Each cycle it decides whether the instruction held in OF may advance into the ALU, or whether OF/ID/IF must hold. It keeps a 16-entry register scoreboard for read-after-write hazards; there is no forwarding. It consumes the ALU's registered branch result and generates the PC redirect and a multi-cycle squash of the younger stages.

## Interface
Parameters:
- WB_LAT, 3: cycles from issue until a written register is readable from the register file.
- LOAD_EXTRA, 1: additional busy cycles for loads.
- FLUSH_CYC, 2: total cycles `flush` stays high per taken branch; must be 1..7.
- Constraint: WB_LAT+LOAD_EXTRA ≤ 7.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- of_valid  in  1  OF holds a valid instruction.
- of_src1, of_src2  in  4 each  source register indices.
- of_src1_used, of_src2_used  in  1 each  source is actually read.
- of_dst  in  4  destination register (reg_to_be_written).
- of_is_write  in  1  instruction writes of_dst.
- of_is_load  in  1  instruction is a load.
- ex_branch  in  9  {isBranch[8], BranchPC[7:0]} straight from the ALU.
- issue  out  1  OF→EX advance this cycle.
- stall  out  1  hold IF/ID/OF.
- flush  out  1  squash IF/ID/OF contents.
- pc_load  out  1  load PC with pc_target.
- pc_target  out  8  redirect address (ex_branch[7:0]).
- busy_mask  out  16  bit r = scoreboard counter r nonzero.

## Operation
- State:
  - cnt[0..15], 3 bits each.
  - flush_cnt, 3 bits.
- Hazard:
  - haz = (of_src1_used & cnt[of_src1]≠0) | (of_src2_used & cnt[of_src2]≠0).
  - WAW and of_dst never stall.
- Combinational outputs, when rst is low:
  - br = ex_branch[8] & (flush_cnt==0). A branch arriving while flush_cnt≠0 is ignored.
  - pc_load = br.
  - pc_target = ex_branch[7:0], always passed through.
  - flush = br | (flush_cnt≠0).
  - issue = of_valid & ~haz & ~flush.
  - stall = of_valid & ~issue & ~flush.
  - busy_mask[r] = (cnt[r]≠0).
- Scoreboard update, every edge:
  - Every nonzero cnt decrements by 1.
  - If issue & of_is_write: cnt[of_dst] ← WB_LAT + (of_is_load ? LOAD_EXTRA : 0). The load overrides the decrement of the same entry.
  - Squashed or stalled instructions never touch the scoreboard.
- Flush counter:
  - On br: flush_cnt ← FLUSH_CYC−1.
  - Otherwise, if nonzero: decrement.

## Timing
- Reset, asynchronous:
  - All cnt = 0 and flush_cnt = 0.
  - While rst is high: issue = stall = flush = pc_load = 0 and busy_mask = 0.
  - pc_target still passes through.
- Hazard release: an instruction issued at edge N with WB_LAT=3 marks its dst busy for cycles N+1..N+3. A dependent instruction issues in cycle N+4.
- Redirect: pc_load/flush is high in the same cycle ex_branch[8] is high, i.e. one cycle after the branch entered EX. flush stays high FLUSH_CYC consecutive cycles.
- Branch with a RAW hazard in OF: flush dominates; stall=0.
- Reset mid-flush or with busy entries: state clears immediately, with no residual flush.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cyc (16 bits) and perf_flush_evt (16 bits).
  - perf_stall_cyc counts cycles with stall=1.
  - perf_flush_evt counts pc_load pulses.
  - Both saturate at 16'hFFFF and clear on rst.
- HAZ_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with of_valid=1 and no sources used -> issue=1 on the first cycle; busy_mask=0.
- Issue an ALU op with dst=R5 at cycle 0, then a consumer with src1=R5 -> stall=1 for cycles 1..3; issue=1 at cycle 4; busy_mask[5] high for cycles 1..3.
- Load to R2, then a consumer with src2=R2 -> stall for 4 cycles (WB_LAT+LOAD_EXTRA).
- ex_branch=9'h1_3C -> pc_load=1, pc_target=8'h3C, and flush high 2 cycles. A second ex_branch=9'h1_10 in the next cycle is ignored (pc_load=0). issue=0 throughout.
- Branch while OF is stalled on a hazard -> stall=0, flush=1, and the scoreboard is unchanged by the squashed instruction.
- Assert rst asynchronously mid-stall with busy_mask=16'h0024 -> all outputs 0 before the next edge. After release, the previously hazarded instruction issues immediately. With HAZ_PERF_CNT_EN, the perf counters read 0.
